// File: rtl/battle_resolver.sv
// Per-tick combat sequencer: finds each side's front unit, strobes a move,
// accumulates each side's damage and delivers it to the opposing front unit.
module battle_resolver #(
  parameter int N  = 4,
  parameter int PW = 9,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [N*PW-1:0] p_pos,
  input  logic [N*2-1:0]  p_type,
  input  logic [N*DW-1:0] p_dmg,
  input  logic [N*PW-1:0] e_pos,
  input  logic [N*2-1:0]  e_type,
  input  logic [N*DW-1:0] e_dmg,
  output logic            move_scen,
  output logic            damage_scen,
  output logic [PW-1:0]   enemy_front,
  output logic [PW-1:0]   player_front,
  output logic [N*DW-1:0] p_damage_in,
  output logic [N*DW-1:0] e_damage_in,
  output logic            busy,
  output logic            tick_overrun
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DW+1:0] SAT = (DW+2)'((1 << DW) - 1);

  typedef enum logic [2:0] {IDLE, SCAN, MOVE, SETTLE, ACCUM, DAMAGE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   min_q, min_d, max_q, max_d;
  logic [IW-1:0]   pidx_q, pidx_d, eidx_q, eidx_d;
  logic            pfnd_q, pfnd_d, efnd_q, efnd_d;
  logic [PW-1:0]   pfront_q, pfront_d, efront_q, efront_d;
  logic [IW-1:0]   tgt_p_q, tgt_p_d, tgt_e_q, tgt_e_d;
  logic            has_p_q, has_p_d, has_e_q, has_e_d;
  logic [DW:0]     psum_q, psum_d, esum_q, esum_d;
  logic            ovr_q, ovr_d;

  logic [PW-1:0]   cur_ppos, cur_epos;
  logic            cur_plive, cur_elive;
  logic [DW-1:0]   cur_pdmg, cur_edmg;

  // Saturating accumulate; once the sum reaches the ceiling it stays there.
  function automatic logic [DW:0] sat_add(input logic [DW:0] acc, input logic [DW-1:0] v);
    logic [DW+1:0] s;
    s = {1'b0, acc} + {2'b00, v};
    if (s >= SAT) s = SAT;
    return s[DW:0];
  endfunction

  assign cur_ppos  = p_pos[idx_q*PW +: PW];
  assign cur_epos  = e_pos[idx_q*PW +: PW];
  assign cur_plive = (p_type[idx_q*2 +: 2] != 2'd0);
  assign cur_elive = (e_type[idx_q*2 +: 2] != 2'd0);
  assign cur_pdmg  = p_dmg[idx_q*DW +: DW];
  assign cur_edmg  = e_dmg[idx_q*DW +: DW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      min_q    <= '1;
      max_q    <= '0;
      pidx_q   <= '0;
      eidx_q   <= '0;
      pfnd_q   <= 1'b0;
      efnd_q   <= 1'b0;
      pfront_q <= '1;
      efront_q <= '0;
      tgt_p_q  <= '0;
      tgt_e_q  <= '0;
      has_p_q  <= 1'b0;
      has_e_q  <= 1'b0;
      psum_q   <= '0;
      esum_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      min_q    <= min_d;
      max_q    <= max_d;
      pidx_q   <= pidx_d;
      eidx_q   <= eidx_d;
      pfnd_q   <= pfnd_d;
      efnd_q   <= efnd_d;
      pfront_q <= pfront_d;
      efront_q <= efront_d;
      tgt_p_q  <= tgt_p_d;
      tgt_e_q  <= tgt_e_d;
      has_p_q  <= has_p_d;
      has_e_q  <= has_e_d;
      psum_q   <= psum_d;
      esum_q   <= esum_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    min_d    = min_q;
    max_d    = max_q;
    pidx_d   = pidx_q;
    eidx_d   = eidx_q;
    pfnd_d   = pfnd_q;
    efnd_d   = efnd_q;
    pfront_d = pfront_q;
    efront_d = efront_q;
    tgt_p_d  = tgt_p_q;
    tgt_e_d  = tgt_e_q;
    has_p_d  = has_p_q;
    has_e_d  = has_e_q;
    psum_d   = psum_q;
    esum_d   = esum_q;
    ovr_d    = ovr_q | (tick & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
          min_d   = '1;
          max_d   = '0;
          pfnd_d  = 1'b0;
          efnd_d  = 1'b0;
        end
      end
      SCAN: begin
        // First live slot always seeds the search, so a unit sitting at an
        // extreme position is still found; strict compares keep lowest index.
        if (cur_plive && (!pfnd_q || cur_ppos < min_q)) begin
          min_d  = cur_ppos;
          pidx_d = idx_q;
          pfnd_d = 1'b1;
        end
        if (cur_elive && (!efnd_q || cur_epos > max_q)) begin
          max_d  = cur_epos;
          eidx_d = idx_q;
          efnd_d = 1'b1;
        end
        if (idx_q == IW'(N-1)) begin
          pfront_d = pfnd_d ? min_d : '1;
          efront_d = efnd_d ? max_d : '0;
          tgt_p_d  = pidx_d;
          tgt_e_d  = eidx_d;
          has_p_d  = pfnd_d;
          has_e_d  = efnd_d;
          state_d  = MOVE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      MOVE: state_d = SETTLE;
      SETTLE: begin
        state_d = ACCUM;
        idx_d   = '0;
        psum_d  = '0;
        esum_d  = '0;
      end
      ACCUM: begin
        psum_d = sat_add(psum_q, cur_plive ? cur_pdmg : '0);
        esum_d = sat_add(esum_q, cur_elive ? cur_edmg : '0);
        if (idx_q == IW'(N-1)) state_d = DAMAGE;
        else idx_d = idx_q + 1'b1;
      end
      DAMAGE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Damage buses are forced to zero outside the DAMAGE cycle.
  always_comb begin
    p_damage_in = '0;
    e_damage_in = '0;
    if (state_q == DAMAGE) begin
      for (int i = 0; i < N; i++) begin
        if (has_p_q && tgt_p_q == IW'(i)) p_damage_in[i*DW +: DW] = esum_q[DW-1:0];
        if (has_e_q && tgt_e_q == IW'(i)) e_damage_in[i*DW +: DW] = psum_q[DW-1:0];
      end
    end
  end

  assign move_scen    = (state_q == MOVE);
  assign damage_scen  = (state_q == DAMAGE);
  assign busy         = (state_q != IDLE);
  assign enemy_front  = efront_q;
  assign player_front = pfront_q;
  assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_battle_resolver.sv
// Directed bench for battle_resolver: front selection, strobe timing,
// damage routing, saturation, dead-side cases, overrun and mid-round reset.
module tb_battle_resolver;
  localparam int N = 4, PW = 9, DW = 8;

  logic            clk = 1'b0;
  logic            reset, tick;
  logic [N*PW-1:0] p_pos, e_pos;
  logic [N*2-1:0]  p_type, e_type;
  logic [N*DW-1:0] p_dmg, e_dmg;
  logic            move_scen, damage_scen, busy, tick_overrun;
  logic [PW-1:0]   enemy_front, player_front;
  logic [N*DW-1:0] p_damage_in, e_damage_in;

  int n_cmp = 0, n_bad = 0;

  battle_resolver #(.N(N), .PW(PW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .p_pos(p_pos), .p_type(p_type), .p_dmg(p_dmg),
    .e_pos(e_pos), .e_type(e_type), .e_dmg(e_dmg),
    .move_scen(move_scen), .damage_scen(damage_scen),
    .enemy_front(enemy_front), .player_front(player_front),
    .p_damage_in(p_damage_in), .e_damage_in(e_damage_in),
    .busy(busy), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_move"}, 32'(move_scen), 32'd0);
    chk({tag, "_dmg"}, 32'(damage_scen), 32'd0);
    chk({tag, "_pfront"}, 32'(player_front), 32'd511);
    chk({tag, "_efront"}, 32'(enemy_front), 32'd0);
    chk({tag, "_pdin"}, 32'(p_damage_in), 32'd0);
    chk({tag, "_edin"}, 32'(e_damage_in), 32'd0);
    chk({tag, "_ovr"}, 32'(tick_overrun), 32'd0);
  endtask

  // Runs one round; j counts edges with the tick-sampling edge as 1.
  task automatic run_round(input string tag, input logic [PW-1:0] exp_pf, input logic [PW-1:0] exp_ef,
                           input logic [31:0] exp_pdin, input logic [31:0] exp_edin,
                           input bit extra_tick, input bit exp_ovr);
    int j, mcnt, dcnt, mj, dj, idle_j;
    logic [31:0] pv, ev;
    bit stray;
    mcnt = 0; dcnt = 0; mj = 0; dj = 0; idle_j = 0; pv = '1; ev = '1; stray = 0;
    @(negedge clk) tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0; j = 1;
    while (j < 40) begin
      if (move_scen) begin mcnt++; mj = j; end
      if (damage_scen) begin
        dcnt++; dj = j; pv = 32'(p_damage_in); ev = 32'(e_damage_in);
      end else if ((p_damage_in | e_damage_in) != '0) stray = 1;
      if (!busy) begin idle_j = j; break; end
      if (extra_tick && j == 2) tick = 1'b1;
      @(posedge clk); #1; tick = 1'b0; j++;
    end
    chk({tag, "_idle_at"}, 32'(idle_j), 32'd12);
    chk({tag, "_move_at"}, 32'(mj), 32'd5);
    chk({tag, "_dmg_at"}, 32'(dj), 32'd11);
    chk({tag, "_move_cnt"}, 32'(mcnt), 32'd1);
    chk({tag, "_dmg_cnt"}, 32'(dcnt), 32'd1);
    chk({tag, "_pfront"}, 32'(player_front), 32'(exp_pf));
    chk({tag, "_efront"}, 32'(enemy_front), 32'(exp_ef));
    chk({tag, "_pdin"}, pv, exp_pdin);
    chk({tag, "_edin"}, ev, exp_edin);
    chk({tag, "_stray"}, 32'(stray), 32'd0);
    chk({tag, "_ovr"}, 32'(tick_overrun), 32'(exp_ovr));
  endtask

  initial begin
    int dseen, bseen;
    reset = 1'b1; tick = 1'b0;
    p_pos = {9'd400, 9'd250, 9'd250, 9'd300};
    p_type = {2'd1, 2'd1, 2'd1, 2'd1};
    p_dmg = '0;
    e_pos = {9'd0, 9'd150, 9'd200, 9'd100};
    e_type = {2'd0, 2'd1, 2'd1, 2'd1};
    e_dmg = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("por");
    @(negedge clk) reset = 1'b0;

    // Abort during ACCUM: everything returns to reset values, no damage strobe.
    @(negedge clk) tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk) reset = 1'b0;
    dseen = 0; bseen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (damage_scen) dseen++;
      if (busy) bseen++;
    end
    chk("midrst_no_dmg", 32'(dseen), 32'd0);
    chk("midrst_no_busy", 32'(bseen), 32'd0);

    // Fronts with a player tie at 250; no damage configured.
    run_round("front", 9'd250, 9'd200, 32'h0, 32'h0, 1'b0, 1'b0);

    // Player slot 3 dead: psum 96 to enemy 1, esum 192 to player 1.
    p_type = {2'd0, 2'd1, 2'd1, 2'd1};
    p_dmg = {8'd32, 8'd32, 8'd32, 8'd32};
    e_dmg = {8'd0, 8'd64, 8'd64, 8'd64};
    run_round("route", 9'd250, 9'd200, 32'h0000_C000, 32'h0000_6000, 1'b0, 1'b0);

    // Four live players at 128 each saturate at 255.
    p_type = {2'd3, 2'd3, 2'd3, 2'd3};
    p_dmg = {8'd128, 8'd128, 8'd128, 8'd128};
    run_round("sat", 9'd250, 9'd200, 32'h0000_C000, 32'h0000_FF00, 1'b0, 1'b0);

    // No live enemies: enemy side gets nothing even though psum is 96.
    p_type = {2'd0, 2'd1, 2'd1, 2'd1};
    p_dmg = {8'd32, 8'd32, 8'd32, 8'd32};
    e_type = '0;
    run_round("no_enemy", 9'd250, 9'd0, 32'h0, 32'h0, 1'b0, 1'b0);

    // No live players: player side gets nothing even though esum would exist.
    e_type = {2'd0, 2'd1, 2'd1, 2'd1};
    p_type = '0;
    run_round("no_player", 9'd511, 9'd200, 32'h0, 32'h0, 1'b0, 1'b0);

    // Extra tick during SCAN is ignored but flagged; flag is sticky.
    p_type = {2'd0, 2'd1, 2'd1, 2'd1};
    run_round("overrun", 9'd250, 9'd200, 32'h0000_C000, 32'h0000_6000, 1'b1, 1'b1);
    run_round("ovr_sticky", 9'd250, 9'd200, 32'h0000_C000, 32'h0000_6000, 1'b0, 1'b1);

    @(negedge clk) reset = 1'b1;
    #2 chk("ovr_cleared", 32'(tick_overrun), 32'd0);
    @(negedge clk) reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
